io_toggle_master: RTL and testbench
===================================

// Module: io_toggle_master
// PURPOSE
//  CPU-side initiator for the toggle-handshake peripheral I/O bus (iord/iowr req/ack pairs).
//  Turns a single CPU I/O request (byte or word, read or write) into one or two byte cycles toward a peripheral.
//  Captures read data and reports completion; optional watchdog aborts cycles to absent/hung ports.
//  Sits between the CPU bus-unit and the peripheral fabric (OPL2, timers, etc.).
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles waited for ack before abort (only with IO_TIMEOUT_EN); range 2..65535
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset_n      in   1   synchronous active-low reset
//  req          in   1   1-cycle request strobe, sampled only when busy=0
//  req_wr       in   1   1=write, 0=read
//  req_word     in   1   1=16-bit access (two byte cycles), 0=8-bit
//  req_port     in   12  I/O port address
//  req_wdata    in   16  write data; [7:0] low byte, [15:8] high byte
//  busy         out  1   access in progress / post-reset sync
//  done         out  1   1-cycle pulse at access completion
//  rdata        out  16  read data, valid from done until next req accepted
//  timed_out    out  1   set with done if any byte cycle aborted; cleared on next accept
//  port         out  12  address to peripherals, stable for whole byte cycle
//  dout         out  8   write byte to peripherals, stable for whole byte cycle
//  din          in   8   read byte from addressed peripheral
//  iord_req     out  1   read request toggle
//  iord_ack     in   1   read acknowledge toggle
//  iowr_req     out  1   write request toggle
//  iowr_ack     in   1   write acknowledge toggle
// BEHAVIOUR
//  Reset (reset_n=0 at edge): iord_req=iowr_req=0, busy=1, done=0, timed_out=0, rdata=16'h0000,
//   port=12'h000, dout=8'h00, state=SYNC. Aborts any in-flight cycle; peripherals may not be reset.
//  States: SYNC -> IDLE -> ISSUE -> WAIT -> (ISSUE for high byte) -> FIN -> IDLE.
//  SYNC: one cycle; iord_req<=iord_ack, iowr_req<=iowr_ack (adopt peripheral levels); busy=1. -> IDLE.
//  IDLE: busy=0. On req: latch req_* fields, clear timed_out, busy=1, byte index=0. -> ISSUE.
//  ISSUE: drive port=req_port (+1 for high byte, 12-bit wrap: 12'hFFF+1=12'h000), dout=selected byte;
//   toggle iord_req (read) or iowr_req (write). -> WAIT. Exactly one toggle per byte cycle.
//  WAIT: pending = (iord_req^iord_ack) or (iowr_req^iowr_ack). When pending=0:
//   read -> capture din into rdata byte (low first, little-endian); -> ISSUE if word & index 0 (index=1),
//   else -> FIN. port/dout held unchanged throughout WAIT.
//  FIN: done=1 for one cycle, busy=0 same cycle. -> IDLE. req in FIN cycle is ignored.
//  Byte read: req@T0 -> toggle visible T1 -> done >= T3 (ack 1 cycle after toggle gives done@T3).
//  req while busy=1: ignored, no side effects. Ack toggle in IDLE: ignored (no stray capture).
//  8-bit read: rdata[15:8] forced 8'h00.
//  Ack level must be compared combinationally each cycle; no double-sync (same clock domain).
// CONFIGURATION
//  IO_TIMEOUT_EN defined: WAIT counts cycles from 0; at count==TIMEOUT_CYCLES-1 with ack still pending:
//   set req toggle back equal to ack (withdraw), read byte=8'hFF, timed_out=1, continue as if acked
//   (word access still runs high-byte cycle). Late ack after withdrawal leaves levels equal: no effect.
//  IO_TIMEOUT_EN undefined: no counter, WAIT holds indefinitely; timed_out tied 0.
// TESTING
//  Byte write 8'h04 to 12'h388, ack 1 cycle later -> one iowr_req toggle, port=388, dout=04, done@T3.
//  Word read 12'h389, ack after 64 cycles each, din 8'h60 then 8'h1F -> port 389 then 38A, rdata=16'h1F60.
//  Word write 16'hBEEF to 12'hFFF -> byte EF@FFF then BE@000, two iowr toggles, one done pulse.
//  req held every cycle during access -> only first accepted; second access starts after IDLE.
//  IO_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack on read -> done@~T18, rdata=16'h00FF, timed_out=1,
//   iord_req==iord_ack afterward; later ack toggle from peripheral causes no extra done.
//  reset_n low mid-WAIT with iord_ack=1 -> after release SYNC copies iord_req=1, busy=0 next cycle.

Source files
------------

// File: rtl/io_toggle_master_if.sv
// Peripheral-side toggle-handshake bus for io_toggle_master.
// The master drives the address, the write byte and both request toggles.
// The peripheral returns the read byte and both acknowledge toggles.
interface io_toggle_master_if;
  logic [11:0] port;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        iord_req;
  logic        iord_ack;
  logic        iowr_req;
  logic        iowr_ack;

  modport master (
    output port, dout, iord_req, iowr_req,
    input  din, iord_ack, iowr_ack
  );

  modport slave (
    input  port, dout, iord_req, iowr_req,
    output din, iord_ack, iowr_ack
  );
endinterface

// File: rtl/io_toggle_master.sv
// CPU-side initiator for the toggle-handshake peripheral I/O bus.
// Turns one CPU I/O request (byte or word, read or write) into one or two byte cycles.
// Optional feature: define IO_TIMEOUT_EN to enable the ack watchdog (TIMEOUT_CYCLES).
// Without it, byte cycles wait indefinitely and timed_out stays 0.
module io_toggle_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_word,
  input  logic [11:0] req_port,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        timed_out,
  io_toggle_master_if.master bus
);

  typedef enum logic [2:0] {StSync, StIdle, StIssue, StWait, StFin} state_e;

  state_e      state_q;
  logic [11:0] port_q;
  logic [7:0]  dout_q;
  logic        iord_req_q;
  logic        iowr_req_q;
  logic        wr_q;
  logic        word_q;
  logic        idx_q;
  logic [11:0] base_q;
  logic [7:0]  whi_q;

  logic        pending;
  logic        expired;
  logic [7:0]  rd_byte;

  assign bus.port     = port_q;
  assign bus.dout     = dout_q;
  assign bus.iord_req = iord_req_q;
  assign bus.iowr_req = iowr_req_q;

  // Same clock domain as the peripherals, so the ack levels are compared directly.
  assign pending = (iord_req_q ^ bus.iord_ack) | (iowr_req_q ^ bus.iowr_ack);

`ifdef IO_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign expired = pending && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign expired = 1'b0;
`endif

  // An aborted read returns all-ones, like a floating data bus.
  assign rd_byte = expired ? 8'hFF : bus.din;

  // Access sequencer: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StSync;
      busy       <= 1'b1;
      done       <= 1'b0;
      rdata      <= 16'h0000;
      timed_out  <= 1'b0;
      port_q     <= 12'h000;
      dout_q     <= 8'h00;
      iord_req_q <= 1'b0;
      iowr_req_q <= 1'b0;
      wr_q       <= 1'b0;
      word_q     <= 1'b0;
      idx_q      <= 1'b0;
      base_q     <= 12'h000;
      whi_q      <= 8'h00;
`ifdef IO_TIMEOUT_EN
      cnt_q      <= 16'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StSync: begin
          // Peripherals keep their levels across our reset; adopt them.
          iord_req_q <= bus.iord_ack;
          iowr_req_q <= bus.iowr_ack;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        StIdle: begin
          if (req) begin
            wr_q      <= req_wr;
            word_q    <= req_word;
            base_q    <= req_port;
            whi_q     <= req_wdata[15:8];
            idx_q     <= 1'b0;
            timed_out <= 1'b0;
            rdata     <= 16'h0000;
            busy      <= 1'b1;
            // Low byte is issued straight away so its toggle shows the cycle after req.
            port_q    <= req_port;
            dout_q    <= req_wdata[7:0];
            if (req_wr) iowr_req_q <= ~iowr_req_q;
            else        iord_req_q <= ~iord_req_q;
`ifdef IO_TIMEOUT_EN
            cnt_q     <= 16'd0;
`endif
            state_q   <= StWait;
          end
        end
        StIssue: begin
          // High byte of a word access; address wraps within 12 bits.
          port_q <= base_q + 12'd1;
          dout_q <= whi_q;
          if (wr_q) iowr_req_q <= ~iowr_req_q;
          else      iord_req_q <= ~iord_req_q;
`ifdef IO_TIMEOUT_EN
          cnt_q  <= 16'd0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (!pending || expired) begin
            if (expired) begin
              // Withdraw the request so a late ack leaves the levels equal.
              iord_req_q <= bus.iord_ack;
              iowr_req_q <= bus.iowr_ack;
              timed_out  <= 1'b1;
            end
            if (!wr_q) begin
              if (idx_q) rdata[15:8] <= rd_byte;
              else       rdata[7:0]  <= rd_byte;
            end
            if (word_q && !idx_q) begin
              idx_q   <= 1'b1;
              state_q <= StIssue;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StFin;
            end
          end
`ifdef IO_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StSync;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_toggle_master.sv
// Bench for io_toggle_master: directed cases plus randomized accesses against a
// transaction-level model of the expected byte cycles and read data.
module tb_io_toggle_master;

`ifdef IO_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 255;
`endif
  localparam int LONG = (TO > 70) ? 64 : 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        req_wr;
  logic        req_word;
  logic [11:0] req_port;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        timed_out;

  io_toggle_master_if bus ();

  io_toggle_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_wr    (req_wr),
    .req_word  (req_word),
    .req_port  (req_port),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .timed_out (timed_out),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [11:0] port;
    logic [7:0]  data;
  } cyc_t;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          ack_delay = 1;
  bit          silent = 1'b0;
  logic [7:0]  mem [4096];
  cyc_t        obs_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Peripheral model: records each byte cycle, acks after ack_delay cycles.
  initial begin
    bus.iord_ack = 1'b0;
    bus.iowr_ack = 1'b0;
    bus.din      = 8'h00;
    forever begin
      @(negedge clk);
      if (!silent && reset_n === 1'b1 &&
          ((bus.iord_req !== bus.iord_ack) || (bus.iowr_req !== bus.iowr_ack))) begin
        cyc_t c;
        c.wr   = (bus.iowr_req !== bus.iowr_ack);
        c.port = bus.port;
        c.data = c.wr ? bus.dout : mem[bus.port];
        obs_q.push_back(c);
        repeat (ack_delay) @(posedge clk);
        #1;
        check("port_stable", 32'(bus.port), 32'(c.port));
        if (c.wr) check("dout_stable", 32'(bus.dout), 32'(c.data));
        if (c.wr) begin
          bus.iowr_ack = ~bus.iowr_ack;
        end else begin
          bus.din      = c.data;
          bus.iord_ack = ~bus.iord_ack;
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!(busy === 1'b0 && done === 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Entered just after the accepting edge; returns at the negedge of the done cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (done !== 1'b1 && lat < 1000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic access(input bit wr, input bit word, input logic [11:0] p,
                        input logic [15:0] wd, input int delay);
    int          lat;
    int          exp_lat;
    logic [11:0] ep;
    logic [15:0] er;
    ack_delay = delay;
    wait_ready();
    obs_q.delete();
    req = 1'b1; req_wr = wr; req_word = word; req_port = p; req_wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    wait_done(lat);
    // Toggle visible 1 cycle after req, ack d cycles later, 1 cycle to decide per byte.
    exp_lat = word ? (2 * delay + 4) : (delay + 2);
    check("done_latency", 32'(lat), 32'(exp_lat));
    check("byte_cycles", 32'(obs_q.size()), word ? 32'd2 : 32'd1);
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      ep = p + 12'(i);
      check("cycle_port", 32'(obs_q[i].port), 32'(ep));
      check("cycle_dir", 32'(obs_q[i].wr), 32'(wr));
      if (wr) check("cycle_wbyte", 32'(obs_q[i].data), (i == 0) ? 32'(wd[7:0]) : 32'(wd[15:8]));
    end
    if (!wr) begin
      er = word ? {mem[p + 12'd1], mem[p]} : {8'h00, mem[p]};
      check("rdata", 32'(rdata), 32'(er));
    end
    check("timed_out_clear", 32'(timed_out), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    bit          rw;
    bit          rwo;
    logic [11:0] rp;
    logic [15:0] rwd;
    int          rd;
    int          lat;
    int          dc;
    logic [15:0] rsave;

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h389] = 8'h60;
    mem[12'h38A] = 8'h1F;

    reset_n = 1'b0; req = 1'b0; req_wr = 1'b0; req_word = 1'b0;
    req_port = 12'h000; req_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    check("rst_port", 32'(bus.port), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_iord_req", 32'(bus.iord_req), 32'd0);
    check("rst_iowr_req", 32'(bus.iowr_req), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("sync_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Directed cases from the block description.
    access(1'b1, 1'b0, 12'h388, 16'h0004, 1);
    access(1'b0, 1'b1, 12'h389, 16'h0000, LONG);
    check("word_read_value", 32'(rdata), 32'h1F60);
    dc = done_cnt;
    access(1'b1, 1'b1, 12'hFFF, 16'hBEEF, 2);
    check("word_write_one_done", 32'(done_cnt - dc), 32'd1);
    access(1'b0, 1'b0, 12'h010, 16'h0000, 1);

    // req held high: FIN-cycle req ignored, next access taken once IDLE.
    ack_delay = 2;
    wait_ready();
    obs_q.delete();
    dc = done_cnt;
    req = 1'b1; req_wr = 1'b1; req_word = 1'b0; req_port = 12'h123; req_wdata = 16'h005A;
    @(posedge clk);
    #1;
    wait_done(lat);
    check("held_first_cycles", 32'(obs_q.size()), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 req = 1'b0;
    wait_done(lat);
    check("held_total_cycles", 32'(obs_q.size()), 32'd2);
    @(negedge clk);
    check("held_done_pulses", 32'(done_cnt - dc), 32'd2);

    // Randomized accesses, with address wrap at 12'hFFF mixed in.
    for (int k = 0; k < 40; k++) begin
      rw  = 1'($urandom_range(0, 1));
      rwo = 1'($urandom_range(0, 1));
      rp  = (k % 8 == 0) ? 12'hFFF : 12'($urandom);
      rwd = 16'($urandom);
      rd  = $urandom_range(1, 6);
      access(rw, rwo, rp, rwd, rd);
    end

    // Stray ack toggles while idle must be ignored.
    wait_ready();
    silent = 1'b1;
    dc = done_cnt;
    rsave = rdata;
    bus.iord_ack = ~bus.iord_ack;
    repeat (5) @(negedge clk);
    bus.iord_ack = ~bus.iord_ack;
    repeat (3) @(negedge clk);
    check("stray_no_done", 32'(done_cnt - dc), 32'd0);
    check("stray_rdata", 32'(rdata), 32'(rsave));
    check("stray_busy", 32'(busy), 32'd0);

`ifdef IO_TIMEOUT_EN
    // No ack at all: watchdog aborts the read.
    wait_ready();
    req = 1'b1; req_wr = 1'b0; req_word = 1'b0; req_port = 12'h200;
    @(posedge clk);
    #1 req = 1'b0;
    wait_done(lat);
    check("to_latency", 32'(lat), 32'(TO + 1));
    check("to_rdata", 32'(rdata), 32'h00FF);
    check("to_flag", 32'(timed_out), 32'd1);
    check("to_withdrawn", 32'(bus.iord_req), 32'(bus.iord_ack));
    dc = done_cnt;
    repeat (2) @(negedge clk);
    bus.iord_ack = ~bus.iord_ack;
    repeat (5) @(negedge clk);
    check("to_late_ack_no_done", 32'(done_cnt - dc), 32'd0);
    bus.iord_ack = ~bus.iord_ack;
`endif

    // Reset in the middle of a read that is never acked, peripheral ack level 1.
    wait_ready();
    req = 1'b1; req_wr = 1'b0; req_word = 1'b0; req_port = 12'h055;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    bus.iord_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst2_sync_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("rst2_iord_adopt", 32'(bus.iord_req), 32'd1);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_done", 32'(done), 32'd0);
    silent = 1'b0;

    // Normal operation after resync.
    access(1'b0, 1'b1, 12'h389, 16'h0000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
